// File: rtl/sad_search_ctrl_pkg.sv
// Shared constants, FSM state type and the per-pixel tag that rides the
// block-matching SAD pipeline.
package me_pkg;
   localparam int BLK       = 16;
   localparam int WIN       = 32;
   localparam int PIX_W     = 8;
   localparam int NCAND     = WIN - BLK + 1;
   localparam int CURR_AW   = 8;
   localparam int SEARCH_AW = 10;
   localparam int SAD_W     = 16;
   localparam int OFF_W     = 5;
   localparam int DRAIN_CYC = 3;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   typedef struct packed {
      logic             vld;
      logic             first;
      logic             last;
      logic [OFF_W-1:0] dx;
      logic [OFF_W-1:0] dy;
   } pix_tag_t;
endpackage

// File: rtl/sad_search_ctrl_if.sv
// Control, memory-read and result signals of the SAD search sequencer.
interface sad_search_ctrl_if;
   import me_pkg::*;

   logic                 start_i;
   logic                 abort_i;
   logic                 busy_o;
   logic                 done_o;
   logic [CURR_AW-1:0]   curr_raddr_o;
   logic [SEARCH_AW-1:0] search_raddr_o;
   logic [PIX_W-1:0]     curr_rdata_i;
   logic [PIX_W-1:0]     search_rdata_i;
   logic [SAD_W-1:0]     best_sad_o;
   logic [OFF_W-1:0]     best_dx_o;
   logic [OFF_W-1:0]     best_dy_o;
   logic                 result_valid_o;

   modport slave (
      input  start_i, abort_i, curr_rdata_i, search_rdata_i,
      output busy_o, done_o, curr_raddr_o, search_raddr_o,
             best_sad_o, best_dx_o, best_dy_o, result_valid_o
   );

   modport master (
      output start_i, abort_i, curr_rdata_i, search_rdata_i,
      input  busy_o, done_o, curr_raddr_o, search_raddr_o,
             best_sad_o, best_dx_o, best_dy_o, result_valid_o
   );
endinterface

// File: rtl/sad_search_ctrl_min_unit.sv
// Absdiff register, per-candidate accumulator and strict-less minimum tracker.
// Tags enter aligned with the address stage and are delayed to meet the data.
module sad_min_unit
   import me_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             flush_i,
   input  pix_tag_t         tag_i,
   input  logic [PIX_W-1:0] curr_i,
   input  logic [PIX_W-1:0] search_i,
   output logic [SAD_W-1:0] best_sad_o,
   output logic [OFF_W-1:0] best_dx_o,
   output logic [OFF_W-1:0] best_dy_o
);
   pix_tag_t         tag1_q, tag2_q;
   logic [PIX_W-1:0] absd_q, absd_d;
   logic [SAD_W-1:0] acc_q, acc_d;
   logic [SAD_W-1:0] best_q;
   logic [OFF_W-1:0] bdx_q, bdy_q;

   always_comb begin
      absd_d = (curr_i > search_i) ? (curr_i - search_i) : (search_i - curr_i);
      acc_d  = tag2_q.first ? SAD_W'(absd_q) : (acc_q + SAD_W'(absd_q));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tag1_q <= '0;
         tag2_q <= '0;
         absd_q <= '0;
         acc_q  <= '0;
         best_q <= '1;
         bdx_q  <= '0;
         bdy_q  <= '0;
      end else begin
         if (clear_i || flush_i) begin
            tag1_q <= '0;
            tag2_q <= '0;
         end else begin
            tag1_q <= tag_i;
            tag2_q <= tag1_q;
         end
         absd_q <= absd_d;
         if (tag2_q.vld) acc_q <= acc_d;
         // all-ones is unreachable, so the first finished candidate always wins
         if (clear_i) begin
            best_q <= '1;
            bdx_q  <= '0;
            bdy_q  <= '0;
         end else if (tag2_q.vld && tag2_q.last && (acc_d < best_q)) begin
            best_q <= acc_d;
            bdx_q  <= tag2_q.dx;
            bdy_q  <= tag2_q.dy;
         end
      end
   end

   assign best_sad_o = best_q;
   assign best_dx_o  = bdx_q;
   assign best_dy_o  = bdy_q;
endmodule

// File: rtl/sad_search_ctrl.sv
// Full-search SAD sequencer: walks every candidate offset, issues memory reads
// one pixel per cycle and publishes the minimum SAD with a done pulse.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | issuing addresses, j inner, then i, dx, dy outer
// DRAIN | letting the last pixels leave the pipeline
// DONE  | publish best result, pulse done_o
module sad_search_ctrl #(
   parameter int BLK = me_pkg::BLK,
   parameter int WIN = me_pkg::WIN
) (
   input logic              clk_i,
   input logic              rst_i,
   sad_search_ctrl_if.slave bus
);
   import me_pkg::*;

   localparam int               NC       = WIN - BLK + 1;
   localparam logic [OFF_W-1:0] LAST_IJ  = OFF_W'(BLK - 1);
   localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(NC - 1);

   state_e               state_q, state_d;
   logic [OFF_W-1:0]     j_q, j_d, i_q, i_d, dx_q, dx_d, dy_q, dy_d;
   logic [1:0]           drain_q, drain_d;
   logic [CURR_AW-1:0]   caddr_q, caddr_d;
   logic [SEARCH_AW-1:0] saddr_q, saddr_d;
   pix_tag_t             tag0_q, tag0_d;
   logic                 done_q, done_d, rvalid_q, rvalid_d;
   logic [SAD_W-1:0]     bsad_q, bsad_d, run_sad;
   logic [OFF_W-1:0]     bdx_q, bdx_d, bdy_q, bdy_d, run_dx, run_dy;
   logic                 clear, flush;

   always_comb begin
      state_d  = state_q;
      j_d      = j_q;
      i_d      = i_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      drain_d  = drain_q;
      caddr_d  = caddr_q;
      saddr_d  = saddr_q;
      tag0_d   = '0;
      done_d   = 1'b0;
      rvalid_d = rvalid_q;
      bsad_d   = bsad_q;
      bdx_d    = bdx_q;
      bdy_d    = bdy_q;
      clear    = 1'b0;
      flush    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d  = RUN;
               j_d      = '0;
               i_d      = '0;
               dx_d     = '0;
               dy_d     = '0;
               rvalid_d = 1'b0;
               clear    = 1'b1;
            end
         end
         RUN: begin
            if (bus.abort_i) begin
               state_d = IDLE;
               flush   = 1'b1;
            end else begin
               caddr_d      = CURR_AW'(int'(i_q) * BLK + int'(j_q));
               saddr_d      = SEARCH_AW'((int'(dy_q) + int'(i_q)) * WIN + int'(dx_q) + int'(j_q));
               tag0_d.vld   = 1'b1;
               tag0_d.first = (i_q == '0) && (j_q == '0);
               tag0_d.last  = (i_q == LAST_IJ) && (j_q == LAST_IJ);
               tag0_d.dx    = dx_q;
               tag0_d.dy    = dy_q;
               j_d = j_q + 1'b1;
               if (j_q == LAST_IJ) begin
                  j_d = '0;
                  i_d = i_q + 1'b1;
                  if (i_q == LAST_IJ) begin
                     i_d  = '0;
                     dx_d = dx_q + 1'b1;
                     if (dx_q == LAST_OFF) begin
                        dx_d = '0;
                        dy_d = dy_q + 1'b1;
                        if (dy_q == LAST_OFF) begin
                           dy_d    = '0;
                           state_d = DRAIN;
                           drain_d = 2'(DRAIN_CYC - 1);
                        end
                     end
                  end
               end
            end
         end
         DRAIN: begin
            if (bus.abort_i) begin
               state_d = IDLE;
               flush   = 1'b1;
            end else if (drain_q == '0) begin
               state_d = DONE;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         DONE: begin
            done_d   = 1'b1;
            rvalid_d = 1'b1;
            bsad_d   = run_sad;
            bdx_d    = run_dx;
            bdy_d    = run_dy;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         j_q      <= '0;
         i_q      <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         drain_q  <= '0;
         caddr_q  <= '0;
         saddr_q  <= '0;
         tag0_q   <= '0;
         done_q   <= 1'b0;
         rvalid_q <= 1'b0;
         bsad_q   <= '0;
         bdx_q    <= '0;
         bdy_q    <= '0;
      end else begin
         state_q  <= state_d;
         j_q      <= j_d;
         i_q      <= i_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         drain_q  <= drain_d;
         caddr_q  <= caddr_d;
         saddr_q  <= saddr_d;
         tag0_q   <= tag0_d;
         done_q   <= done_d;
         rvalid_q <= rvalid_d;
         bsad_q   <= bsad_d;
         bdx_q    <= bdx_d;
         bdy_q    <= bdy_d;
      end
   end

   sad_min_unit u_min (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear),
      .flush_i    (flush),
      .tag_i      (tag0_q),
      .curr_i     (bus.curr_rdata_i),
      .search_i   (bus.search_rdata_i),
      .best_sad_o (run_sad),
      .best_dx_o  (run_dx),
      .best_dy_o  (run_dy)
   );

   assign bus.busy_o         = (state_q != IDLE);
   assign bus.done_o         = done_q;
   assign bus.curr_raddr_o   = caddr_q;
   assign bus.search_raddr_o = saddr_q;
   assign bus.best_sad_o     = bsad_q;
   assign bus.best_dx_o      = bdx_q;
   assign bus.best_dy_o      = bdy_q;
   assign bus.result_valid_o = rvalid_q;
endmodule
